// File: rtl/i2c_bus_checker.sv
// i2c_bus_checker
// Passive I2C bus monitor. It synchronises and glitch-filters SCL/SDA, then
// decodes START, repeated START, STOP, data bytes and ACK/NACK. It flags
// START/STOP conditions inside a byte and SCL-low timeouts, and it keeps
// sticky error bits and a saturating error counter. It never drives the bus.
//
// Ports
//   clk, rst_n            system clock, async active-low reset
//   enable                0 holds the decoder idle and suppresses pulses
//   clr_i                 synchronous clear of err_sticky / err_count
//   scl_i, sda_i          asynchronous bus lines
//   bus_busy              START seen, no STOP/timeout yet
//   start_det, rstart_det, stop_det, byte_valid,
//   err_misplaced, err_timeout      single-cycle pulses
//   byte_data/ack/first   fields of the last decoded byte
//   err_sticky[1:0]       [0] misplaced seen, [1] timeout seen
//   err_count             saturating error total
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | bus free, waiting for START
// ST_BUSY | transfer in progress, decoding bits and bytes
module i2c_bus_checker #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 3,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 clr_i,
    input  logic                 scl_i,
    input  logic                 sda_i,
    output logic                 bus_busy,
    output logic                 start_det,
    output logic                 rstart_det,
    output logic                 stop_det,
    output logic                 byte_valid,
    output logic [7:0]           byte_data,
    output logic                 byte_ack,
    output logic                 byte_first,
    output logic                 err_misplaced,
    output logic                 err_timeout,
    output logic [1:0]           err_sticky,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FC_W = $clog2(FILTER_LEN + 1);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic [FC_W-1:0]        scl_fcnt_q, scl_fcnt_d, sda_fcnt_q, sda_fcnt_d;
    logic                   scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic                   scl_p_q, sda_p_q;

    state_t                 state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   first_q, first_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;

    logic                   busy_q, busy_d, start_q, start_d, rstart_q, rstart_d;
    logic                   stop_q, stop_d, valid_q, valid_d;
    logic [7:0]             data_q, data_d;
    logic                   ack_q, ack_d, bfirst_q, bfirst_d;
    logic                   misp_q, misp_d, tout_q, tout_d;
    logic [1:0]             sticky_q, sticky_d;
    logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;

    logic                   scl_s, sda_s, scl_rise, start_c, stop_c;

    // Input synchronisers and glitch filters
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES-1];

        scl_f_d    = scl_f_q;
        scl_fcnt_d = '0;
        if (scl_s != scl_f_q) begin
            if (scl_fcnt_q == FC_W'(FILTER_LEN - 1)) scl_f_d = scl_s;
            else                                     scl_fcnt_d = scl_fcnt_q + 1'b1;
        end

        sda_f_d    = sda_f_q;
        sda_fcnt_d = '0;
        if (sda_s != sda_f_q) begin
            if (sda_fcnt_q == FC_W'(FILTER_LEN - 1)) sda_f_d = sda_s;
            else                                     sda_fcnt_d = sda_fcnt_q + 1'b1;
        end
    end

    // Any SCL change disqualifies START/STOP, so simultaneous edges resolve to SCL.
    assign scl_rise = scl_f_q & ~scl_p_q;
    assign start_c  = scl_f_q & scl_p_q &  sda_p_q & ~sda_f_q;
    assign stop_c   = scl_f_q & scl_p_q & ~sda_p_q &  sda_f_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        first_d   = first_q;
        to_cnt_d  = '0;
        start_d   = 1'b0;
        rstart_d  = 1'b0;
        stop_d    = 1'b0;
        valid_d   = 1'b0;
        misp_d    = 1'b0;
        tout_d    = 1'b0;
        data_d    = data_q;
        ack_d     = ack_q;
        bfirst_d  = bfirst_q;

        if (!enable) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_c) begin
                        state_d   = ST_BUSY;
                        start_d   = 1'b1;
                        bit_cnt_d = '0;
                        first_d   = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (!scl_f_q) begin
                        if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                            tout_d    = 1'b1;
                            state_d   = ST_IDLE;
                            bit_cnt_d = '0;
                        end else begin
                            to_cnt_d = to_cnt_q + 1'b1;
                        end
                    end
                    // A STOP/START right after the ACK sees bit_cnt = 1 because
                    // its own SCL rise has already been counted.
                    if (start_c) begin
                        rstart_d  = 1'b1;
                        misp_d    = (bit_cnt_q > 4'd1);
                        bit_cnt_d = '0;
                        first_d   = 1'b1;
                    end else if (stop_c) begin
                        stop_d    = 1'b1;
                        misp_d    = (bit_cnt_q > 4'd1);
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                    end else if (scl_rise) begin
                        if (bit_cnt_q == 4'd8) begin
                            data_d    = shift_q;
                            ack_d     = sda_f_q;
                            bfirst_d  = first_q;
                            first_d   = 1'b0;
                            valid_d   = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            shift_d   = {shift_q[6:0], sda_f_q};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_BUSY);

        // Clear first, then apply this cycle's errors.
        sticky_d = clr_i ? 2'b00 : sticky_q;
        cnt_d    = clr_i ? '0 : cnt_q;
        if (misp_d) begin
            sticky_d[0] = 1'b1;
            if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
        end
        if (tout_d) begin
            sticky_d[1] = 1'b1;
            if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_fcnt_q <= '0;
            sda_fcnt_q <= '0;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            first_q    <= 1'b0;
            to_cnt_q   <= '0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            rstart_q   <= 1'b0;
            stop_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            ack_q      <= 1'b0;
            bfirst_q   <= 1'b0;
            misp_q     <= 1'b0;
            tout_q     <= 1'b0;
            sticky_q   <= '0;
            cnt_q      <= '0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_fcnt_q <= scl_fcnt_d;
            sda_fcnt_q <= sda_fcnt_d;
            scl_f_q    <= scl_f_d;
            sda_f_q    <= sda_f_d;
            scl_p_q    <= scl_f_q;
            sda_p_q    <= sda_f_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            first_q    <= first_d;
            to_cnt_q   <= to_cnt_d;
            busy_q     <= busy_d;
            start_q    <= start_d;
            rstart_q   <= rstart_d;
            stop_q     <= stop_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            bfirst_q   <= bfirst_d;
            misp_q     <= misp_d;
            tout_q     <= tout_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus_busy      = busy_q;
    assign start_det     = start_q;
    assign rstart_det    = rstart_q;
    assign stop_det      = stop_q;
    assign byte_valid    = valid_q;
    assign byte_data     = data_q;
    assign byte_ack      = ack_q;
    assign byte_first    = bfirst_q;
    assign err_misplaced = misp_q;
    assign err_timeout   = tout_q;
    assign err_sticky    = sticky_q;
    assign err_count     = cnt_q;

endmodule

// File: tb/tb_i2c_bus_checker.sv
// Testbench for i2c_bus_checker: drives pin-level I2C transactions and checks
// decoded pulses, byte fields and error accounting.
module tb_i2c_bus_checker;

    localparam int HB = 5;
    localparam int OP_START = 0, OP_BYTE = 1, OP_RSTART = 2, OP_STOP = 3;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, clr_i = 1'b0;
    logic scl_i = 1'b1, sda_i = 1'b1;
    logic bus_busy, start_det, rstart_det, stop_det, byte_valid;
    logic [7:0] byte_data;
    logic byte_ack, byte_first, err_misplaced, err_timeout;
    logic [1:0] err_sticky;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    i2c_bus_checker #(
        .SYNC_STAGES(2), .FILTER_LEN(3), .TIMEOUT_CYCLES(50), .ERR_CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr_i(clr_i),
        .scl_i(scl_i), .sda_i(sda_i), .bus_busy(bus_busy),
        .start_det(start_det), .rstart_det(rstart_det), .stop_det(stop_det),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ack(byte_ack),
        .byte_first(byte_first), .err_misplaced(err_misplaced),
        .err_timeout(err_timeout), .err_sticky(err_sticky), .err_count(err_count)
    );

    int total = 0, bad = 0;
    int n_start = 0, n_rstart = 0, n_stop = 0, n_valid = 0, n_misp = 0, n_tout = 0;
    int s_start, s_rstart, s_stop, s_valid, s_misp, s_tout;
    logic [9:0] cap_q[$];

    always @(negedge clk) begin
        if (start_det)     n_start++;
        if (rstart_det)    n_rstart++;
        if (stop_det)      n_stop++;
        if (err_misplaced) n_misp++;
        if (err_timeout)   n_tout++;
        if (byte_valid) begin
            n_valid++;
            cap_q.push_back({byte_first, byte_ack, byte_data});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_start = n_start; s_rstart = n_rstart; s_stop = n_stop;
        s_valid = n_valid; s_misp = n_misp; s_tout = n_tout;
    endtask

    task automatic do_start();
        sda_i = 1'b0; wait_cyc(HB);
        scl_i = 1'b0; wait_cyc(HB);
    endtask

    task automatic do_rstart();
        sda_i = 1'b1; wait_cyc(HB);
        scl_i = 1'b1; wait_cyc(HB);
        sda_i = 1'b0; wait_cyc(HB);
        scl_i = 1'b0; wait_cyc(HB);
    endtask

    task automatic do_stop();
        sda_i = 1'b0; wait_cyc(HB);
        scl_i = 1'b1; wait_cyc(HB);
        sda_i = 1'b1; wait_cyc(HB);
    endtask

    task automatic send_bit(input logic b);
        sda_i = b;    wait_cyc(HB);
        scl_i = 1'b1; wait_cyc(HB);
        scl_i = 1'b0; wait_cyc(HB);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic a);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(a);
    endtask

    typedef struct {
        int         op;
        logic [7:0] d;
        logic       a;
        int         e_start, e_rstart, e_stop, e_valid;
        logic [7:0] e_data;
        logic       e_ack, e_first, e_busy;
    } vec_t;

    vec_t tbl[9];
    logic [9:0] exp_q[$];

    initial begin
        tbl[0] = '{OP_START,  8'h00, 1'b0, 1, 0, 0, 0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{OP_BYTE,   8'hA0, 1'b0, 0, 0, 0, 1, 8'hA0, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{OP_BYTE,   8'hA5, 1'b0, 0, 0, 0, 1, 8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{OP_STOP,   8'h00, 1'b0, 0, 0, 1, 0, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{OP_START,  8'h00, 1'b0, 1, 0, 0, 0, 8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{OP_BYTE,   8'h91, 1'b1, 0, 0, 0, 1, 8'h91, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{OP_RSTART, 8'h00, 1'b0, 0, 1, 0, 0, 8'h91, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{OP_BYTE,   8'h90, 1'b0, 0, 0, 0, 1, 8'h90, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{OP_STOP,   8'h00, 1'b0, 0, 0, 1, 0, 8'h90, 1'b0, 1'b1, 1'b0};

        // Reset state
        wait_cyc(3);
        chk("rst busy", bus_busy, 0);
        chk("rst pulses", {start_det, rstart_det, stop_det, byte_valid, err_misplaced, err_timeout}, 0);
        chk("rst byte", {byte_first, byte_ack, byte_data}, 0);
        chk("rst err", {err_sticky, err_count}, 0);
        rst_n = 1'b1;
        wait_cyc(10);
        chk("post-rst busy", bus_busy, 0);

        // Latency: pin edge to start_det is 6 cycles, pulse 1 cycle wide
        sda_i = 1'b0;
        wait_cyc(5);
        chk("lat early", start_det, 0);
        wait_cyc(1);
        chk("lat start", start_det, 1);
        chk("lat busy", bus_busy, 1);
        wait_cyc(1);
        chk("lat width", start_det, 0);
        scl_i = 1'b0; wait_cyc(HB);
        do_stop(); wait_cyc(10);
        chk("lat busy off", bus_busy, 0);

        // Table-driven transactions
        for (int i = 0; i < 9; i++) begin
            snap();
            case (tbl[i].op)
                OP_START:  do_start();
                OP_BYTE:   send_byte(tbl[i].d, tbl[i].a);
                OP_RSTART: do_rstart();
                default:   do_stop();
            endcase
            wait_cyc(10);
            chk($sformatf("tbl%0d start", i), n_start - s_start, tbl[i].e_start);
            chk($sformatf("tbl%0d rstart", i), n_rstart - s_rstart, tbl[i].e_rstart);
            chk($sformatf("tbl%0d stop", i), n_stop - s_stop, tbl[i].e_stop);
            chk($sformatf("tbl%0d valid", i), n_valid - s_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d data", i), byte_data, tbl[i].e_data);
            chk($sformatf("tbl%0d ack", i), byte_ack, tbl[i].e_ack);
            chk($sformatf("tbl%0d first", i), byte_first, tbl[i].e_first);
            chk($sformatf("tbl%0d busy", i), bus_busy, tbl[i].e_busy);
        end
        chk("tbl err", {err_sticky, err_count}, 0);

        // Randomised transactions against a transaction-level model
        for (int t = 0; t < 20; t++) begin
            int nb, exp_rs;
            logic [7:0] d;
            logic a, first;
            snap();
            cap_q.delete();
            exp_q.delete();
            exp_rs = 0;
            do_start();
            first = 1'b1;
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                d = 8'($urandom);
                a = 1'($urandom_range(0, 1));
                send_byte(d, a);
                exp_q.push_back({first, a, d});
                first = 1'b0;
            end
            if ($urandom_range(0, 1) == 1) begin
                do_rstart();
                exp_rs++;
                first = 1'b1;
                nb = $urandom_range(1, 2);
                for (int b = 0; b < nb; b++) begin
                    d = 8'($urandom);
                    a = 1'($urandom_range(0, 1));
                    send_byte(d, a);
                    exp_q.push_back({first, a, d});
                    first = 1'b0;
                end
            end
            do_stop();
            wait_cyc(10);
            chk($sformatf("rnd%0d nbytes", t), cap_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++)
                chk($sformatf("rnd%0d byte%0d", t, k), cap_q[k], exp_q[k]);
            chk($sformatf("rnd%0d start", t), n_start - s_start, 1);
            chk($sformatf("rnd%0d rstart", t), n_rstart - s_rstart, exp_rs);
            chk($sformatf("rnd%0d stop", t), n_stop - s_stop, 1);
            chk($sformatf("rnd%0d misp", t), n_misp - s_misp, 0);
        end
        chk("rnd err", {err_sticky, err_count}, 0);

        // Short SDA glitch and simultaneous SCL/SDA edges
        snap();
        sda_i = 1'b0; wait_cyc(2);
        sda_i = 1'b1; wait_cyc(10);
        scl_i = 1'b0; sda_i = 1'b0; wait_cyc(10);
        scl_i = 1'b1; sda_i = 1'b1; wait_cyc(10);
        chk("glitch start", n_start - s_start, 0);
        chk("glitch stop", n_stop - s_stop, 0);
        chk("glitch busy", bus_busy, 0);
        chk("glitch err", {err_sticky, err_count}, 0);

        // enable = 0 suppresses decode
        enable = 1'b0;
        snap();
        do_start();
        send_byte(8'hC3, 1'b0);
        chk("dis busy", bus_busy, 0);
        do_stop(); wait_cyc(10);
        chk("dis pulses", (n_start - s_start) + (n_valid - s_valid) + (n_stop - s_stop), 0);
        enable = 1'b1;
        wait_cyc(10);

        // STOP after 4 data bits
        snap();
        do_start();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        do_stop(); wait_cyc(10);
        chk("misp pulse", n_misp - s_misp, 1);
        chk("misp stop", n_stop - s_stop, 1);
        chk("misp sticky", err_sticky, 2'b01);
        chk("misp count", err_count, 1);
        chk("misp busy", bus_busy, 0);

        // SCL-low timeout
        snap();
        do_start();
        wait_cyc(25);
        chk("to short", n_tout - s_tout, 0);
        chk("to short busy", bus_busy, 1);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        wait_cyc(60);
        chk("to pulse", n_tout - s_tout, 1);
        chk("to busy", bus_busy, 0);
        chk("to sticky", err_sticky, 2'b11);
        chk("to count", err_count, 2);
        snap();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        do_stop(); wait_cyc(10);
        chk("to idle valid", n_valid - s_valid, 0);
        chk("to idle stop", n_stop - s_stop, 0);
        do_start();
        send_byte(8'h3C, 1'b0);
        do_stop(); wait_cyc(10);
        chk("to resume start", n_start - s_start, 1);
        chk("to resume data", {byte_first, byte_ack, byte_data}, {2'b10, 8'h3C});

        // Reset in the middle of a transfer
        do_start();
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        chk("mid busy", bus_busy, 1);
        rst_n = 1'b0;
        wait_cyc(2);
        chk("mid rst busy", bus_busy, 0);
        chk("mid rst byte", byte_data, 0);
        chk("mid rst err", {err_sticky, err_count}, 0);
        rst_n = 1'b1;
        snap();
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        do_stop(); wait_cyc(10);
        chk("mid stop", n_stop - s_stop, 0);
        chk("mid valid", n_valid - s_valid, 0);
        do_start();
        send_byte(8'h5A, 1'b1);
        do_stop(); wait_cyc(10);
        chk("mid resume", {byte_first, byte_ack, byte_data}, {2'b11, 8'h5A});
        chk("mid resume start", n_start - s_start, 1);

        // Saturation and clear
        clr_i = 1'b1; wait_cyc(1); clr_i = 1'b0;
        chk("clr err", {err_sticky, err_count}, 0);
        snap();
        for (int i = 0; i < 300; i++) begin
            do_start();
            send_bit(1'b1);
            send_bit(1'b0);
            do_stop();
            wait_cyc(3);
        end
        wait_cyc(10);
        chk("sat misp", n_misp - s_misp, 300);
        chk("sat count", err_count, 255);
        chk("sat sticky", err_sticky, 2'b01);
        do_start();
        send_bit(1'b1);
        send_bit(1'b1);
        sda_i = 1'b0; wait_cyc(HB);
        scl_i = 1'b1; wait_cyc(HB);
        sda_i = 1'b1;
        wait_cyc(5);
        clr_i = 1'b1;
        wait_cyc(1);
        clr_i = 1'b0;
        wait_cyc(10);
        chk("clr+err count", err_count, 1);
        chk("clr+err sticky", err_sticky, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
